// File: rtl/img_pkt_ddr_wr.sv
// Drains fixed-length image packets from an FWFT FIFO into DDR as fixed-size write
// bursts, rotating frames through a ring of buffers and checking the XOR parity word.
//
// state     | meaning
// IDLE      | no burst active; waits for a full burst in the FIFO (frame open if word_idx != 0)
// CMD       | burst command presented, address/length held until accepted
// DATA      | streaming BURST_LEN beats from the FIFO head
// BURST_END | decide between frame completion, next burst, or waiting for FIFO fill
// DONE      | frame completion pulse, advance ring buffer, clear frame counters
`timescale 1ns/1ps
module img_pkt_ddr_wr #(
  parameter int          BURST_LEN     = 256,
  parameter int          IMG_WORDS     = 262144,
  parameter int          TRAILER_WORDS = 256,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter logic [31:0] FRAME_STRIDE  = 32'h0010_0400,
  parameter int          NUM_BUFS      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fifo_rddata,
  input  logic        fifo_empty,
  input  logic [9:0]  fifo_rd_count,
  output logic        fifo_rden,
  input  logic        wr_en,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_addr,
  output logic [7:0]  cmd_len,
  output logic [31:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        wr_last,
  output logic        frame_done,
  output logic [31:0] frame_addr,
  output logic [1:0]  frame_type_o,
  output logic        parity_ok,
  output logic [15:0] parity_err_cnt,
  output logic        busy
);

  localparam int              PKT_WORDS = IMG_WORDS + TRAILER_WORDS;
  localparam int              BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [10:0]     BURST_CNT = 11'(BURST_LEN);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [7:0]      CMD_LEN   = 8'(BURST_LEN - 1);
  localparam logic [31:0]     IMG_IDX   = 32'(IMG_WORDS);
  localparam logic [31:0]     TYPE_IDX  = 32'(IMG_WORDS + 4);
  localparam logic [31:0]     PKT_IDX   = 32'(PKT_WORDS);
  localparam logic [3:0]      LAST_BUF  = 4'(NUM_BUFS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMD       = 3'd1,
    DATA      = 3'd2,
    BURST_END = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t        state;
  logic [31:0]   word_idx;
  logic [31:0]   buf_base;
  logic [31:0]   acc;
  logic [3:0]    buf_idx;
  logic [BW-1:0] beat_cnt;
  logic          par_match;
  logic [1:0]    frame_type;

  logic          in_data;
  logic          beat;
  logic          burst_ready;
  logic          frame_open;
  logic [31:0]   next_cmd_addr;

  assign in_data       = (state == DATA);
  assign wr_valid      = in_data & ~fifo_empty;
  assign wr_data       = in_data ? fifo_rddata : 32'h0;
  assign beat          = wr_valid & wr_ready;
  assign fifo_rden     = beat;
  assign wr_last       = wr_valid & (beat_cnt == LAST_BEAT);
  assign frame_open    = (word_idx != 32'h0);
  assign burst_ready   = ({1'b0, fifo_rd_count} >= BURST_CNT);
  // An open frame parked in IDLE still counts as busy.
  assign busy          = (state != IDLE) | frame_open;
  assign next_cmd_addr = buf_base + {word_idx[29:0], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      word_idx       <= 32'h0;
      buf_base       <= BASE_ADDR;
      acc            <= 32'h0;
      buf_idx        <= 4'd0;
      beat_cnt       <= '0;
      par_match      <= 1'b0;
      frame_type     <= 2'd0;
      cmd_valid      <= 1'b0;
      cmd_addr       <= 32'h0;
      cmd_len        <= 8'h0;
      frame_done     <= 1'b0;
      frame_addr     <= 32'h0;
      frame_type_o   <= 2'd0;
      parity_ok      <= 1'b0;
      parity_err_cnt <= 16'h0;
    end else begin
      if (beat) begin
        word_idx <= word_idx + 32'd1;
        beat_cnt <= beat_cnt + 1'b1;
        if (word_idx < IMG_IDX)   acc        <= acc ^ fifo_rddata;
        if (word_idx == IMG_IDX)  par_match  <= (fifo_rddata == acc);
        if (word_idx == TYPE_IDX) frame_type <= fifo_rddata[9:8];
      end

      case (state)
        IDLE: begin
          // New frames need wr_en; a frame already in flight resumes regardless.
          if (burst_ready && (wr_en || frame_open)) begin
            state     <= CMD;
            cmd_valid <= 1'b1;
            cmd_addr  <= next_cmd_addr;
            cmd_len   <= CMD_LEN;
          end
        end
        CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat && (beat_cnt == LAST_BEAT)) state <= BURST_END;
        end
        BURST_END: begin
          if (word_idx == PKT_IDX) begin
            state        <= DONE;
            frame_done   <= 1'b1;
            frame_addr   <= buf_base;
            frame_type_o <= frame_type;
            parity_ok    <= par_match;
            if (!par_match && (parity_err_cnt != 16'hFFFF))
              parity_err_cnt <= parity_err_cnt + 16'd1;
          end else if (burst_ready) begin
            state     <= CMD;
            cmd_valid <= 1'b1;
            cmd_addr  <= next_cmd_addr;
            cmd_len   <= CMD_LEN;
          end else begin
            state <= IDLE;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          word_idx   <= 32'h0;
          acc        <= 32'h0;
          state      <= IDLE;
          if (buf_idx == LAST_BUF) begin
            buf_idx  <= 4'd0;
            buf_base <= BASE_ADDR;
          end else begin
            buf_idx  <= buf_idx + 4'd1;
            buf_base <= buf_base + FRAME_STRIDE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_pkt_ddr_wr.sv
// Scoreboard bench for img_pkt_ddr_wr: randomized packets through a modelled FWFT FIFO,
// expected DDR commands, data and frame results derived from the packet layout.
`timescale 1ns/1ps
module tb_img_pkt_ddr_wr;

  localparam int          BURST_LEN     = 256;
  localparam int          IMG_WORDS     = 1024;
  localparam int          TRAILER_WORDS = 256;
  localparam int          NUM_BUFS      = 4;
  localparam int          PKT           = IMG_WORDS + TRAILER_WORDS;
  localparam logic [31:0] BASE_ADDR     = 32'h0000_0000;
  localparam logic [31:0] FRAME_STRIDE  = 32'h0000_1400;
  localparam int          FIFO_DEPTH    = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fifo_rddata = 32'h0;
  logic        fifo_empty = 1'b1;
  logic [9:0]  fifo_rd_count = 10'd0;
  logic        fifo_rden;
  logic        wr_en = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic        wr_last;
  logic        frame_done;
  logic [31:0] frame_addr;
  logic [1:0]  frame_type_o;
  logic        parity_ok;
  logic [15:0] parity_err_cnt;
  logic        busy;

  always #5 clk = ~clk;

  img_pkt_ddr_wr #(
    .BURST_LEN(BURST_LEN), .IMG_WORDS(IMG_WORDS), .TRAILER_WORDS(TRAILER_WORDS),
    .BASE_ADDR(BASE_ADDR), .FRAME_STRIDE(FRAME_STRIDE), .NUM_BUFS(NUM_BUFS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_rddata(fifo_rddata), .fifo_empty(fifo_empty), .fifo_rd_count(fifo_rd_count),
    .fifo_rden(fifo_rden), .wr_en(wr_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_last(wr_last),
    .frame_done(frame_done), .frame_addr(frame_addr), .frame_type_o(frame_type_o),
    .parity_ok(parity_ok), .parity_err_cnt(parity_err_cnt), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  ftype;
    logic        ok;
    logic [15:0] errs;
  } frame_t;

  logic [31:0] src_q[$];
  logic [31:0] fifo_q[$];
  logic [31:0] exp_cmd_q[$];
  logic [31:0] exp_data_q[$];
  frame_t      exp_frame_q[$];
  logic [31:0] pkt[PKT];

  int checks = 0;
  int errors = 0;
  int m_buf = 0;
  int m_err = 0;
  bit bp_mode = 1'b0;
  bit uf_arm = 1'b0;
  int force_cnt = 0;

  bit          pop_s = 1'b0;
  bit          in_burst = 1'b0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_cmd_addr = 32'h0;
  int          burst_beat = 0;
  int          frame_beat = 0;
  int          cmd_wait = 0;
  int          done_cnt = 0;
  int          cmd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic void fifo_outputs();
    fifo_empty    = (fifo_q.size() == 0) || (force_cnt > 0);
    fifo_rddata   = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    fifo_rd_count = fifo_empty ? 10'd0 : 10'(fifo_q.size());
  endfunction

  // FIFO, feeder and ready generation; all input changes land 1ns after the rising edge.
  always begin
    @(posedge clk);
    #1;
    if (pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (src_q.size() > 0 && fifo_q.size() < FIFO_DEPTH && $urandom_range(0, 7) != 0)
      fifo_q.push_back(src_q.pop_front());
    if (force_cnt > 0) force_cnt--;
    else if (uf_arm && in_burst && burst_beat == 100) begin
      force_cnt = 10;
      uf_arm = 1'b0;
    end
    cmd_ready = bp_mode ? (cmd_wait >= 3) : 1'b1;
    wr_ready  = bp_mode ? ~wr_ready : 1'b1;
    fifo_outputs();
  end

  // Monitor: observes what the coming rising edge will do and scores it.
  always @(negedge clk) begin
    pop_s = fifo_rden;
    if (!rst_n) begin
      in_burst   = 1'b0;
      prev_wait  = 1'b0;
      burst_beat = 0;
      frame_beat = 0;
      cmd_wait   = 0;
    end else begin
      chk("wr_valid", {31'b0, wr_valid}, {31'b0, in_burst && !fifo_empty});
      chk("fifo_rden", {31'b0, fifo_rden}, {31'b0, in_burst && !fifo_empty && wr_ready});
      if (in_burst) chk("cmd_valid_in_burst", {31'b0, cmd_valid}, 32'd0);
      if (prev_wait) begin
        chk("cmd_valid_held", {31'b0, cmd_valid}, 32'd1);
        chk("cmd_addr_stable", cmd_addr, prev_cmd_addr);
      end
      if (wr_valid && wr_ready) begin
        if (exp_data_q.size() == 0) fail("unexpected_beat");
        else chk("wr_data", wr_data, exp_data_q.pop_front());
        chk("wr_last", {31'b0, wr_last}, {31'b0, burst_beat == BURST_LEN - 1});
        chk("busy_in_burst", {31'b0, busy}, 32'd1);
        burst_beat++;
        frame_beat++;
        if (burst_beat == BURST_LEN) in_burst = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) fail("unexpected_cmd");
        else chk("cmd_addr", cmd_addr, exp_cmd_q.pop_front());
        chk("cmd_len", {24'b0, cmd_len}, 32'd255);
        in_burst   = 1'b1;
        burst_beat = 0;
        cmd_cnt++;
        cmd_wait   = 0;
        prev_wait  = 1'b0;
      end else if (cmd_valid) begin
        cmd_wait++;
        prev_wait     = 1'b1;
        prev_cmd_addr = cmd_addr;
      end else begin
        prev_wait = 1'b0;
      end
      if (frame_done) begin
        if (exp_frame_q.size() == 0) fail("unexpected_frame_done");
        else begin
          frame_t f;
          f = exp_frame_q.pop_front();
          chk("frame_addr", frame_addr, f.addr);
          chk("frame_type", {30'b0, frame_type_o}, {30'b0, f.ftype});
          chk("parity_ok", {31'b0, parity_ok}, {31'b0, f.ok});
          chk("parity_err_cnt", {16'b0, parity_err_cnt}, {16'b0, f.errs});
        end
        frame_beat = 0;
        done_cnt++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic build_frame(input bit incr, input bit corrupt);
    logic [31:0] x;
    x = 32'h0;
    for (int i = 0; i < PKT; i++) pkt[i] = 32'h0;
    for (int i = 0; i < IMG_WORDS; i++) begin
      pkt[i] = incr ? 32'(i) : $urandom();
      x ^= pkt[i];
    end
    pkt[IMG_WORDS]     = x ^ {31'b0, corrupt};
    pkt[IMG_WORDS + 4] = incr ? 32'h0000_0200 : $urandom();
    pkt[IMG_WORDS + 5] = $urandom();
    pkt[IMG_WORDS + 6] = $urandom();
  endtask

  task automatic push_src();
    for (int i = 0; i < PKT; i++) src_q.push_back(pkt[i]);
  endtask

  task automatic push_exp();
    frame_t      f;
    logic [31:0] x;
    logic [31:0] base;
    logic [31:0] dw0;
    x    = 32'h0;
    base = BASE_ADDR + FRAME_STRIDE * 32'(m_buf);
    for (int k = 0; k < PKT / BURST_LEN; k++) exp_cmd_q.push_back(base + 32'(k * BURST_LEN * 4));
    for (int i = 0; i < PKT; i++) begin
      exp_data_q.push_back(pkt[i]);
      if (i < IMG_WORDS) x ^= pkt[i];
    end
    dw0     = pkt[IMG_WORDS + 4];
    f.addr  = base;
    f.ftype = dw0[9:8];
    f.ok    = (x == pkt[IMG_WORDS]);
    if (!f.ok && m_err < 65535) m_err++;
    f.errs  = 16'(m_err);
    exp_frame_q.push_back(f);
    m_buf = (m_buf + 1) % NUM_BUFS;
  endtask

  task automatic wait_frames(input int n);
    int target;
    int cnt;
    target = done_cnt + n;
    cnt = 0;
    while (done_cnt < target && cnt < n * 5000) begin
      cyc(1);
      cnt++;
    end
    if (done_cnt < target) fail("frame_timeout");
    cyc(2);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_cmd_valid"}, {31'b0, cmd_valid}, 32'd0);
    chk({tag, "_cmd_addr"}, cmd_addr, 32'd0);
    chk({tag, "_cmd_len"}, {24'b0, cmd_len}, 32'd0);
    chk({tag, "_wr_valid"}, {31'b0, wr_valid}, 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_wr_last"}, {31'b0, wr_last}, 32'd0);
    chk({tag, "_fifo_rden"}, {31'b0, fifo_rden}, 32'd0);
    chk({tag, "_frame_done"}, {31'b0, frame_done}, 32'd0);
    chk({tag, "_frame_addr"}, frame_addr, 32'd0);
    chk({tag, "_frame_type"}, {30'b0, frame_type_o}, 32'd0);
    chk({tag, "_parity_ok"}, {31'b0, parity_ok}, 32'd0);
    chk({tag, "_parity_err_cnt"}, {16'b0, parity_err_cnt}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int c0;
    int d0;
    int cnt;
    fifo_outputs();
    cyc(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    cyc(2);
    wr_en = 1'b1;

    // nominal incrementing frame, type 2, good parity
    build_frame(1'b1, 1'b0);
    push_src();
    push_exp();
    wait_frames(1);

    // parity word with bit 0 flipped
    build_frame(1'b0, 1'b1);
    push_src();
    push_exp();
    wait_frames(1);

    // command and data backpressure
    bp_mode = 1'b1;
    build_frame(1'b0, 1'b0);
    push_src();
    push_exp();
    wait_frames(1);
    bp_mode = 1'b0;

    // FIFO runs dry for 10 cycles at beat 100 of the first burst
    uf_arm = 1'b1;
    build_frame(1'b0, 1'b0);
    push_src();
    push_exp();
    wait_frames(1);

    // five back-to-back frames wrap the buffer ring
    for (int n = 0; n < 5; n++) begin
      build_frame(1'b0, n[0]);
      push_src();
      push_exp();
    end
    wait_frames(5);

    // reset at beat 500 of the second frame
    d0 = done_cnt;
    for (int n = 0; n < 2; n++) begin
      build_frame(1'b0, 1'b0);
      push_src();
      push_exp();
    end
    cnt = 0;
    while (!(done_cnt >= d0 + 1 && frame_beat >= 500) && cnt < 10000) begin
      cyc(1);
      cnt++;
    end
    if (cnt >= 10000) fail("reset_point_timeout");
    chk("frame2_beat_before_reset", 32'(frame_beat), 32'd500);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midframe_reset");
    src_q.delete();
    fifo_q.delete();
    exp_cmd_q.delete();
    exp_data_q.delete();
    exp_frame_q.delete();
    force_cnt = 0;
    fifo_outputs();
    m_buf = 0;
    m_err = 0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // frame after reset starts at BASE_ADDR; wr_en dropped mid-frame
    build_frame(1'b0, 1'b0);
    push_src();
    push_exp();
    c0 = cmd_cnt;
    cnt = 0;
    while (cmd_cnt == c0 && cnt < 5000) begin
      cyc(1);
      cnt++;
    end
    if (cmd_cnt == c0) fail("first_cmd_timeout");
    wr_en = 1'b0;
    wait_frames(1);

    // next frame must stay blocked while wr_en is low
    c0 = cmd_cnt;
    d0 = done_cnt;
    build_frame(1'b0, 1'b1);
    push_src();
    cyc(1500);
    chk("blocked_cmds", 32'(cmd_cnt), 32'(c0));
    chk("blocked_done", 32'(done_cnt), 32'(d0));
    chk("blocked_busy", {31'b0, busy}, 32'd0);
    push_exp();
    wr_en = 1'b1;
    wait_frames(1);

    cyc(5);
    chk("leftover_cmds", 32'(exp_cmd_q.size()), 32'd0);
    chk("leftover_data", 32'(exp_data_q.size()), 32'd0);
    chk("leftover_frames", 32'(exp_frame_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
